// File: rtl/fpga_clk_pkg.sv
// Package for the multi-channel slow-clock generator.
// Provides the divider width, the minimum legal ratio, the ratio type,
// the per-channel state encoding and the ratio clamp helper.
package fpga_clk_pkg;

  localparam int unsigned DIV_W   = 16;
  localparam int unsigned MIN_DIV = 2;

  typedef logic [DIV_W-1:0] div_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } ch_state_e;

  // Ratios below MIN_DIV cannot form a high and a low phase, so they are raised to MIN_DIV.
  function automatic div_t clamp_div(input div_t n);
    div_t r;
    if (n < div_t'(MIN_DIV)) begin
      r = div_t'(MIN_DIV);
    end else begin
      r = n;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpga_clk_div_ch.sv
// One divided-clock channel: period counter, pending-ratio register with
// valid/ready handshake, and the IDLE/RUN/STOPPING sequencer.
// Ports:
//   clk_i        reference clock
//   rst_i        asynchronous active-high reset
//   locked_i     generator settle time has elapsed
//   en_i         run enable
//   div_valid_i  new-ratio request
//   div_i        requested ratio (clamped to >= 2 when latched)
//   div_ready_o  no ratio pending, a new one can be accepted
//   clk_o        divided clock, registered
module fpga_clk_div_ch
  import fpga_clk_pkg::*;
#(
  parameter div_t DEFAULT_DIV = DIV_W'(4)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic locked_i,
  input  logic en_i,
  input  logic div_valid_i,
  input  div_t div_i,
  output logic div_ready_o,
  output logic clk_o
);

  ch_state_e state_q, state_d;
  div_t      cnt_q, cnt_d;
  div_t      act_q, act_d;
  div_t      pend_q, pend_d;
  logic      pend_v_q, pend_v_d;
  logic      clk_q, clk_d;

  div_t      hi_s;
  logic      boundary_s;
  logic      tick_s;

  // High phase length is ceil(N/2); the counter wraps after position N-1.
  assign hi_s       = act_q - (act_q >> 1);
  assign boundary_s = (cnt_q == (act_q - div_t'(1)));

  // Sequencer, period counter, ratio apply and handshake next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    act_d    = act_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    clk_d    = 1'b0;
    tick_s   = 1'b0;

    case (state_q)
      IDLE: begin
        if (en_i && locked_i) begin
          tick_s  = 1'b1;
          state_d = RUN;
        end else begin
          tick_s  = 1'b0;
          state_d = IDLE;
        end
      end
      RUN: begin
        tick_s = 1'b1;
        if (en_i) begin
          state_d = RUN;
        end else if (boundary_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOPPING;
        end
      end
      STOPPING: begin
        // Re-enable before the boundary resumes without a gap.
        tick_s = 1'b1;
        if (en_i) begin
          state_d = RUN;
        end else if (boundary_s) begin
          state_d = IDLE;
        end else begin
          state_d = STOPPING;
        end
      end
      default: begin
        tick_s  = 1'b0;
        state_d = IDLE;
      end
    endcase

    if (tick_s) begin
      clk_d = (cnt_q < hi_s);
      if (boundary_s) begin
        cnt_d = div_t'(0);
        // Only a ratio pending before this cycle is applied, so a transfer
        // coinciding with the boundary waits for the next one.
        if (pend_v_q) begin
          act_d    = pend_q;
          pend_v_d = 1'b0;
        end else begin
          act_d    = act_q;
        end
      end else begin
        cnt_d = cnt_q + div_t'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end

    if (div_valid_i && !pend_v_q) begin
      pend_d   = clamp_div(div_i);
      pend_v_d = 1'b1;
    end else begin
      pend_d   = pend_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= div_t'(0);
      act_q    <= DEFAULT_DIV;
      pend_q   <= DEFAULT_DIV;
      pend_v_q <= 1'b0;
      clk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      clk_q    <= clk_d;
    end
  end

  assign div_ready_o = ~pend_v_q;
  assign clk_o       = clk_q;

endmodule

// File: rtl/fpga_clk_div_gen.sv
// Multi-channel runtime-programmable slow-clock generator.
// Holds the settle/lock counter and slices the per-channel ports onto
// NUM_CH independent fpga_clk_div_ch instances.
// Ports:
//   ref_clk_i    reference clock, the only clock
//   rst_i        asynchronous active-high reset
//   en_i         per-channel run enable
//   div_valid_i  per-channel new-ratio request
//   div_i        per-channel ratio, channel c at [c*DIV_W +: DIV_W]
//   div_ready_o  per-channel ready for a new ratio
//   clk_o        divided clocks, registered
//   locked_o     settle time elapsed; stays high until reset
module fpga_clk_div_gen #(
  parameter int               NUM_CH      = 2,
  parameter int               DIV_W       = 16,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd4,
  parameter int               LOCK_CYCLES = 16
) (
  input  logic                    ref_clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       div_valid_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  output logic [NUM_CH-1:0]       div_ready_o,
  output logic [NUM_CH-1:0]       clk_o,
  output logic                    locked_o
);

  localparam int LOCK_W = ($clog2(LOCK_CYCLES + 1) > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

  if (DIV_W != int'(fpga_clk_pkg::DIV_W)) begin : g_div_w_check
    $error("DIV_W must equal fpga_clk_pkg::DIV_W");
  end

  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              locked_q, locked_d;

  // Lock counter: counts LOCK_CYCLES edges, then raises locked one edge later.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    locked_d   = locked_q;
    if (!locked_q) begin
      if (lock_cnt_q == LOCK_W'(LOCK_CYCLES)) begin
        locked_d = 1'b1;
      end else begin
        lock_cnt_d = lock_cnt_q + LOCK_W'(1);
      end
    end else begin
      locked_d = 1'b1;
    end
  end

  // Lock registers.
  always_ff @(posedge ref_clk_i or posedge rst_i) begin
    if (rst_i) begin
      lock_cnt_q <= LOCK_W'(0);
      locked_q   <= 1'b0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      locked_q   <= locked_d;
    end
  end

  assign locked_o = locked_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    fpga_clk_div_ch #(
      .DEFAULT_DIV (fpga_clk_pkg::div_t'(DEFAULT_DIV))
    ) u_ch (
      .clk_i       (ref_clk_i),
      .rst_i       (rst_i),
      .locked_i    (locked_q),
      .en_i        (en_i[c]),
      .div_valid_i (div_valid_i[c]),
      .div_i       (div_i[c*DIV_W +: DIV_W]),
      .div_ready_o (div_ready_o[c]),
      .clk_o       (clk_o[c])
    );
  end

endmodule

// File: tb/tb_fpga_clk_div_gen.sv
// Self-checking bench for fpga_clk_div_gen: a phase-count behavioural model
// is compared against the DUT every cycle, with literal waveform pins.
module tb_fpga_clk_div_gen;

  localparam int NC   = 2;
  localparam int DW   = 16;
  localparam int LOCK = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NC-1:0]    en;
  logic [NC-1:0]    valid;
  logic [NC*DW-1:0] div;
  logic [NC-1:0]    ready;
  logic [NC-1:0]    clko;
  logic             locked;

  int tests = 0;
  int fails = 0;

  // Behavioural model: remaining high/low cycles of the current period.
  bit m_run [NC];
  int m_n   [NC];
  int m_hl  [NC];
  int m_ll  [NC];
  int m_pend[NC];
  bit m_pv  [NC];
  bit m_clk [NC];
  int m_edges;
  bit m_locked;

  fpga_clk_div_gen #(
    .NUM_CH      (NC),
    .DIV_W       (DW),
    .DEFAULT_DIV (16'd4),
    .LOCK_CYCLES (LOCK)
  ) dut (
    .ref_clk_i   (clk),
    .rst_i       (rst),
    .en_i        (en),
    .div_valid_i (valid),
    .div_i       (div),
    .div_ready_o (ready),
    .clk_o       (clko),
    .locked_o    (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int ch, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s ch%0d: got %0h, expected %0h at %0t", name, ch, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_run[c] = 1'b0; m_n[c] = 4; m_hl[c] = 0; m_ll[c] = 0;
      m_pend[c] = 0; m_pv[c] = 1'b0; m_clk[c] = 1'b0;
    end
    m_edges = 0; m_locked = 1'b0;
  endtask

  task automatic model_edge();
    bit lk;
    bit pv;
    bit tick;
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    lk = m_locked;
    if (m_edges <= LOCK) m_edges++;
    m_locked = (m_edges > LOCK);
    for (int c = 0; c < NC; c++) begin
      pv   = m_pv[c];
      tick = m_run[c] || (en[c] && lk);
      if (tick) begin
        if (m_hl[c] == 0 && m_ll[c] == 0) begin
          m_hl[c] = m_n[c] - m_n[c] / 2;
          m_ll[c] = m_n[c] / 2;
        end
        if (m_hl[c] > 0) begin m_clk[c] = 1'b1; m_hl[c]--; end
        else begin m_clk[c] = 1'b0; m_ll[c]--; end
        if (m_hl[c] == 0 && m_ll[c] == 0) begin
          if (pv) begin m_n[c] = m_pend[c]; m_pv[c] = 1'b0; end
          m_run[c] = en[c];
        end else begin
          m_run[c] = 1'b1;
        end
      end else begin
        m_clk[c] = 1'b0;
      end
      if (valid[c] && !pv) begin
        d = int'(div[c*DW +: DW]);
        m_pend[c] = (d < 2) ? 2 : d;
        m_pv[c]   = 1'b1;
      end
    end
  endtask

  // One clock: model advances at the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int c = 0; c < NC; c++) begin
      chk("clk_o", c, 64'(clko[c]), 64'(m_clk[c]));
      chk("div_ready_o", c, 64'(ready[c]), 64'(!m_pv[c]));
    end
    chk("locked_o", -1, 64'(locked), 64'(m_locked));
  endtask

  task automatic req(input int c, input int d);
    logic [31:0] dv;
    dv = d;
    valid[c] = 1'b1;
    div[c*DW +: DW] = dv[15:0];
    step();
    valid[c] = 1'b0;
  endtask

  task automatic wait_ready(input int c, output int n);
    n = 0;
    while (!ready[c] && n < 64) begin
      step();
      n++;
    end
    chk("ready_timeout", c, 64'(ready[c]), 64'd1);
  endtask

  task automatic trace(input int c, input int n, output logic [63:0] t);
    t = 64'd0;
    for (int i = 0; i < n; i++) begin
      step();
      t = {t[62:0], clko[c]};
    end
  endtask

  initial begin
    logic [63:0] t;
    int n;
    bit h[48];
    int run;
    int minrun;
    int ones0;
    bit seen;

    rst = 1'b1; en = '0; valid = '0; div = '0;
    model_reset();
    repeat (3) step();
    chk("reset_clk", -1, 64'(clko), 64'd0);
    chk("reset_locked", -1, 64'(locked), 64'd0);
    chk("reset_ready", -1, 64'(ready), 64'd3);

    // Lock sequence with both channels enabled.
    en = 2'b11; rst = 1'b0;
    repeat (LOCK) step();
    chk("not_locked_16", -1, 64'(locked), 64'd0);
    chk("clk_held_16", -1, 64'(clko), 64'd0);
    step();
    chk("locked_17", -1, 64'(locked), 64'd1);
    trace(0, 8, t);
    chk("div4_wave", 0, t, 64'b11001100);

    // Ratio 5 while running.
    req(0, 5);
    chk("ready_drop5", 0, 64'(ready[0]), 64'd0);
    wait_ready(0, n);
    chk("apply5_delay", 0, 64'(n), 64'd3);
    trace(0, 10, t);
    chk("div5_wave", 0, t, 64'b1110011100);

    // Ratios 0 and 1 clamp to 2.
    req(0, 0);
    wait_ready(0, n);
    trace(0, 4, t);
    chk("div0_wave", 0, t, 64'b1010);
    req(0, 1);
    wait_ready(0, n);
    trace(0, 4, t);
    chk("div1_wave", 0, t, 64'b1010);

    // Ratio 7 transferred exactly at the boundary of an N=8 period.
    req(0, 8);
    wait_ready(0, n);
    repeat (7) step();
    req(0, 7);
    chk("ready_drop7", 0, 64'(ready[0]), 64'd0);
    wait_ready(0, n);
    chk("apply7_delay", 0, 64'(n), 64'd8);
    trace(0, 7, t);
    chk("div7_wave", 0, t, 64'b1111000);

    // Enable dropped at cnt=1 of N=8, then reasserted at cnt=6.
    req(0, 8);
    wait_ready(0, n);
    step();
    en[0] = 1'b0;
    trace(0, 10, t);
    chk("stop_wave", 0, t, 64'b1110000000);
    en[0] = 1'b1;
    step();
    en[0] = 1'b0;
    repeat (5) step();
    en[0] = 1'b1;
    trace(0, 12, t);
    chk("resume_wave", 0, t, 64'b001111000011);

    // Reset mid high phase with a pending request on ch1.
    req(1, 9);
    chk("ready_drop9", 1, 64'(ready[1]), 64'd0);
    chk("pre_rst_high", 0, 64'(clko[0]), 64'd1);
    rst = 1'b1;
    #1;
    chk("rst_clk", -1, 64'(clko), 64'd0);
    chk("rst_locked", -1, 64'(locked), 64'd0);
    chk("rst_ready", -1, 64'(ready), 64'd3);
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    repeat (LOCK + 1) step();
    trace(1, 8, t);
    chk("post_rst_div4", 1, t, 64'b11001100);

    // ch0 N=3, ch1 N=10, then ch1 changed to 6.
    req(0, 3);
    req(1, 10);
    wait_ready(0, n);
    wait_ready(1, n);
    repeat (30) step();
    req(1, 6);
    ones0 = 0;
    for (int i = 0; i < 48; i++) begin
      step();
      h[i] = clko[1];
      ones0 += int'(clko[0]);
    end
    chk("ch0_ones_n3", 0, 64'(ones0), 64'd32);
    run = 1; minrun = 99; seen = 1'b0;
    for (int i = 1; i < 48; i++) begin
      if (h[i] == h[i-1]) begin
        run++;
      end else begin
        if (seen && run < minrun) minrun = run;
        seen = 1'b1;
        run = 1;
      end
    end
    chk("ch1_min_phase", 1, 64'(minrun >= 3 && minrun < 99), 64'd1);

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 999) == 0);
      for (int c = 0; c < NC; c++) begin
        if ($urandom_range(0, 19) == 0) en[c] = ~en[c];
        valid[c] = ($urandom_range(0, 5) == 0);
        if ($urandom_range(0, 7) == 0) div[c*DW +: DW] = 16'($urandom_range(13, 40));
        else div[c*DW +: DW] = 16'($urandom_range(0, 12));
      end
      step();
    end
    rst = 1'b0; valid = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
